// File: rtl/mem_port_arbiter_if.sv
// Bundles the load/store, debug, halt and RAM port-B signals of mem_port_arbiter.
// slave is the arbiter's view; master is the view of the requesters and the RAM around it.
interface mem_port_arbiter_if #(
  parameter int cXLEN  = 32,
  parameter int cAddrW = 10,
  parameter int cTagW  = 5
);
  logic              iLsReq;
  logic              iLsWrite;
  logic [cAddrW-1:0] iLsAddr;
  logic [cXLEN-1:0]  iLsData;
  logic [cTagW-1:0]  iLsTag;
  logic              oLsGnt;
  logic              oLsRdv;
  logic [cTagW-1:0]  oLsTag;
  logic [cXLEN-1:0]  oLsRData;

  logic              iDbgReq;
  logic              iDbgWrite;
  logic [cAddrW-1:0] iDbgAddr;
  logic [cXLEN-1:0]  iDbgData;
  logic              oDbgGnt;
  logic              oDbgRdv;
  logic [cXLEN-1:0]  oDbgRData;

  logic              iDbgHalt;
  logic              oHalted;
  logic              oFetchNoOp;

  logic              oRamEn;
  logic              oRamWEn;
  logic [cAddrW-1:0] oRamAddr;
  logic [cXLEN-1:0]  oRamWData;
  logic [cXLEN-1:0]  iRamRData;

  modport slave (
    input  iLsReq, iLsWrite, iLsAddr, iLsData, iLsTag,
    output oLsGnt, oLsRdv, oLsTag, oLsRData,
    input  iDbgReq, iDbgWrite, iDbgAddr, iDbgData,
    output oDbgGnt, oDbgRdv, oDbgRData,
    input  iDbgHalt,
    output oHalted, oFetchNoOp,
    output oRamEn, oRamWEn, oRamAddr, oRamWData,
    input  iRamRData
  );

  modport master (
    output iLsReq, iLsWrite, iLsAddr, iLsData, iLsTag,
    input  oLsGnt, oLsRdv, oLsTag, oLsRData,
    output iDbgReq, iDbgWrite, iDbgAddr, iDbgData,
    input  oDbgGnt, oDbgRdv, oDbgRData,
    output iDbgHalt,
    input  oHalted, oFetchNoOp,
    input  oRamEn, oRamWEn, oRamAddr, oRamWData,
    output iRamRData
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares RAM port B between load/store and debug, returns tagged read data, runs the debug halt sequence.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration in RUN; default is fixed LS-over-debug priority.
module mem_port_arbiter #(
  parameter int cXLEN       = 32,
  parameter int cAddrW      = 10,
  parameter int cTagW       = 5,
  parameter int cRamLatency = 1
) (
  input logic               iClk,
  input logic               iRst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} stateT;

  localparam int cLast = cRamLatency - 1;

  stateT             stateReg;
  logic              haltedReg;
  logic              noOpReg;

  logic              lsGnt;
  logic              dbgGnt;
  logic              lsWins;

  logic              cmdEnReg;
  logic              cmdWEnReg;
  logic              cmdLsReg;
  logic [cAddrW-1:0] cmdAddrReg;
  logic [cXLEN-1:0]  cmdWDataReg;
  logic [cTagW-1:0]  cmdTagReg;

  logic [cRamLatency-1:0] pipeValidReg;
  logic [cRamLatency-1:0] pipeLsReg;
  logic [cTagW-1:0]       pipeTagReg [cRamLatency];
  logic [cRamLatency-1:0] lsInFlight;
  logic                   drained;
  logic                   lsRdv;
  logic                   dbgRdv;

`ifdef ARB_ROUND_ROBIN_EN
  // 0 = debug was granted last, so load/store takes the first tie after reset.
  logic lastGntLsReg;

  assign lsWins = !(bus.iDbgReq && lastGntLsReg);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      lastGntLsReg <= 1'b0;
    end else if (lsGnt) begin
      lastGntLsReg <= 1'b1;
    end else if (dbgGnt) begin
      lastGntLsReg <= 1'b0;
    end
  end
`else
  assign lsWins = 1'b1;
`endif

  // Load/store is only ever granted in RUN; debug takes whatever load/store leaves.
  assign lsGnt  = bus.iLsReq && (stateReg == RUN) && lsWins;
  assign dbgGnt = bus.iDbgReq && !lsGnt;

  assign bus.oLsGnt  = lsGnt;
  assign bus.oDbgGnt = dbgGnt;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      cmdEnReg    <= 1'b0;
      cmdWEnReg   <= 1'b0;
      cmdLsReg    <= 1'b0;
      cmdAddrReg  <= '0;
      cmdWDataReg <= '0;
      cmdTagReg   <= '0;
    end else begin
      cmdEnReg    <= lsGnt || dbgGnt;
      cmdWEnReg   <= lsGnt ? bus.iLsWrite : (dbgGnt && bus.iDbgWrite);
      cmdLsReg    <= lsGnt;
      cmdAddrReg  <= lsGnt ? bus.iLsAddr : (dbgGnt ? bus.iDbgAddr : '0);
      cmdWDataReg <= lsGnt ? bus.iLsData : (dbgGnt ? bus.iDbgData : '0);
      cmdTagReg   <= lsGnt ? bus.iLsTag : '0;
    end
  end

  assign bus.oRamEn    = cmdEnReg;
  assign bus.oRamWEn   = cmdWEnReg;
  assign bus.oRamAddr  = cmdAddrReg;
  assign bus.oRamWData = cmdWDataReg;

  // Stage 0 is filled as the RAM sees a read; the last stage lines up with its data.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      pipeValidReg <= '0;
      pipeLsReg    <= '0;
      for (int i = 0; i < cRamLatency; i++) begin
        pipeTagReg[i] <= '0;
      end
    end else begin
      pipeValidReg[0] <= cmdEnReg && !cmdWEnReg;
      pipeLsReg[0]    <= cmdLsReg;
      pipeTagReg[0]   <= cmdTagReg;
      for (int i = 1; i < cRamLatency; i++) begin
        pipeValidReg[i] <= pipeValidReg[i-1];
        pipeLsReg[i]    <= pipeLsReg[i-1];
        pipeTagReg[i]   <= pipeTagReg[i-1];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < cRamLatency; gi++) begin : gLsInFlight
      assign lsInFlight[gi] = pipeValidReg[gi] && pipeLsReg[gi];
    end
  endgenerate

  assign drained = !(cmdEnReg && cmdLsReg) && !(|lsInFlight);

  assign lsRdv  = pipeValidReg[cLast] && pipeLsReg[cLast];
  assign dbgRdv = pipeValidReg[cLast] && !pipeLsReg[cLast];

  assign bus.oLsRdv    = lsRdv;
  assign bus.oLsTag    = lsRdv ? pipeTagReg[cLast] : '0;
  assign bus.oLsRData  = lsRdv ? bus.iRamRData : '0;
  assign bus.oDbgRdv   = dbgRdv;
  assign bus.oDbgRData = dbgRdv ? bus.iRamRData : '0;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateReg  <= RUN;
      haltedReg <= 1'b0;
      noOpReg   <= 1'b0;
    end else begin
      case (stateReg)
        RUN: begin
          if (bus.iDbgHalt) begin
            stateReg <= DRAIN;
            noOpReg  <= 1'b1;
          end
        end
        DRAIN: begin
          if (!bus.iDbgHalt) begin
            stateReg <= RUN;
            noOpReg  <= 1'b0;
          end else if (drained) begin
            stateReg  <= HALTED;
            haltedReg <= 1'b1;
          end
        end
        HALTED: begin
          if (!bus.iDbgHalt) begin
            stateReg  <= RUN;
            haltedReg <= 1'b0;
            noOpReg   <= 1'b0;
          end
        end
        default: begin
          stateReg  <= RUN;
          haltedReg <= 1'b0;
          noOpReg   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oHalted    = haltedReg;
  assign bus.oFetchNoOp = noOpReg;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Owns RAM port B of the unified instruction/data RAM and shares it between two requesters: the core load/store path and the debug/program-loader port.
- Serialises their accesses and routes read data back with its tag.
- Implements a debug halt sequence: stalls fetch, drains in-flight reads, then gives the debugger exclusive use of the port.
- Sits between the load/store stage, the fetch control (noOp) and the RAM.

Parameters:
- cXLEN, 32, data width.
- cAddrW, 10, RAM word-address width.
- cTagW, 5, load/store destination-register tag width.
- cRamLatency, 1, RAM port-B read latency in cycles (1 or 2).

Ports:
- iClk  in  1  clock.
- iRst  in  1  reset, synchronous, active-high.
- iLsReq  in  1  load/store request.
- iLsWrite  in  1  1 = store, 0 = load.
- iLsAddr  in  cAddrW  word address.
- iLsData  in  cXLEN  store data.
- iLsTag  in  cTagW  destination register of a load.
- oLsGnt  out  1  load/store request accepted this cycle.
- oLsRdv  out  1  load data valid.
- oLsTag  out  cTagW  tag returned with the load data.
- oLsRData  out  cXLEN  load data.
- iDbgReq  in  1  debug request.
- iDbgWrite  in  1  1 = write.
- iDbgAddr  in  cAddrW  word address.
- iDbgData  in  cXLEN  write data.
- oDbgGnt  out  1  debug request accepted this cycle.
- oDbgRdv  out  1  debug read data valid.
- oDbgRData  out  cXLEN  debug read data.
- iDbgHalt  in  1  level; 1 = request core halt.
- oHalted  out  1  core halted, port exclusive to debug.
- oFetchNoOp  out  1  drives fetch control noOp.
- oRamEn  out  1  RAM port-B enable.
- oRamWEn  out  1  RAM port-B write enable.
- oRamAddr  out  cAddrW  RAM address.
- oRamWData  out  cXLEN  RAM write data.
- iRamRData  in  cXLEN  RAM port-B read data.

Behaviour:
- Handshake:
  - Transfer occurs when req & gnt are both high in the same cycle.
  - The requester holds req and payload stable until it sees gnt.
  - oLsGnt/oDbgGnt are combinational from req and state; they are never both high.
- RAM command: registered. oRamEn/oRamWEn/oRamAddr/oRamWData reflect the granted request 1 cycle after the handshake; oRamEn=0 in all other cycles.
- Read return:
  - A tag pipeline of depth cRamLatency carries {valid, source, tag}.
  - oXRdv pulses for 1 cycle exactly 1+cRamLatency cycles after the read handshake, with oXRData = iRamRData.
  - oLsTag equals the accepted iLsTag.
  - Writes produce no return.
  - Returns arrive in issue order.
- Throughput: one access per cycle, back-to-back allowed. A read after a write to the same address returns the new data.
- Default arbitration: fixed priority, LS over Dbg, in RUN.
- Halt FSM, states RUN, DRAIN, HALTED:
  - RUN: both requesters arbitrated; oFetchNoOp=0, oHalted=0.
  - RUN -> DRAIN when iDbgHalt=1.
  - DRAIN: oFetchNoOp=1; oLsGnt=0; debug may still be granted. -> HALTED when the tag pipeline holds no valid LS entry and no LS command is in the RAM command register.
  - HALTED: oHalted=1, oFetchNoOp=1, oLsGnt=0. Debug is granted every cycle it requests. -> RUN when iDbgHalt=0, with oFetchNoOp=0 in the RUN cycle.
  - DRAIN with iDbgHalt=0 -> RUN.
- Simultaneous events:
  - An LS handshake in the same cycle iDbgHalt rises completes; its read is drained before HALTED.
  - A debug read issued in DRAIN still returns normally.
- Reset:
  - All outputs 0; state RUN.
  - Tag pipeline and RAM command register cleared.
  - Reads in flight at reset never produce Rdv.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: in RUN, when both requesters are active, the requester not granted most recently wins. A 1-bit last-grant register, reset to Dbg, ensures LS wins the first tie.
- Undefined: fixed priority, LS over Dbg; the debug port can starve under continuous LS traffic.
- DRAIN and HALTED behaviour are identical in both builds.

Test Plan:
- LS read, addr 0x010 preloaded with 0xDEADBEEF, tag 5, cRamLatency=1 -> oLsGnt same cycle; oRamEn=1 with addr 0x010 at +1; oLsRdv=1, oLsRData=0xDEADBEEF, oLsTag=5 at +2.
- LS write 0x12345678 to 0x020, then LS read 0x020 the next cycle -> oRamWEn=1 then 0 in consecutive cycles; read returns 0x12345678.
- LS and Dbg both request for 4 cycles:
  - Without macro: LS granted 4/4.
  - With ARB_ROUND_ROBIN_EN: grants LS, Dbg, LS, Dbg.
- iDbgHalt raised in the same cycle as an LS read handshake -> oFetchNoOp=1 next cycle; oHalted rises only after oLsRdv pulses; oLsGnt=0 while halted; Dbg write 0x00000013 to 0x000 succeeds; iDbgHalt=0 -> oFetchNoOp=0, oHalted=0 next cycle.
- iRst asserted 1 cycle after an LS read handshake -> no oLsRdv ever pulses for that read; all outputs 0 and state RUN on the next cycle.
- cRamLatency=2, back-to-back LS reads at 0x1, 0x2, 0x3 with tags 1, 2, 3 -> oLsRdv high on 3 consecutive cycles starting at +3, tags returned 1, 2, 3 in order.
